// File: rtl/fifo_word_unpacker_if.sv
// Handshake bundle for fifo_word_unpacker: wide FIFO read side in, narrow slice stream out,
// plus the status outputs. The unpacker uses the slave view; whoever drives it uses master.
interface fifo_word_unpacker_if #(
    parameter int unsigned in_width    = 32,
    parameter int unsigned out_width   = 8,
    parameter int unsigned count_width = 16
);
    logic [in_width-1:0]    in_data;
    logic                   in_enable;
    logic                   in_ready;
    logic [out_width-1:0]   out_data;
    logic                   out_enable;
    logic                   out_ready;
    logic                   busy;
    logic [count_width-1:0] count;

    modport master (
        output in_data, in_enable, out_ready,
        input  in_ready, out_data, out_enable, busy, count
    );

    modport slave (
        input  in_data, in_enable, out_ready,
        output in_ready, out_data, out_enable, busy, count
    );
endinterface

// File: rtl/fifo_word_unpacker.sv
// Pops wide words from a FIFO read port and replays each one as in_width/out_width narrow
// slices on an enable/ready stream. The last slice and the next pop share a cycle, so a
// continuously fed input yields one slice per clock with no bubble.
module fifo_word_unpacker #(
    parameter int unsigned in_width    = 32,
    parameter int unsigned out_width   = 8,
    parameter bit          msb_first   = 1'b1,
    parameter int unsigned count_width = 16
) (
    input logic                clk,
    input logic                reset_n,
    fifo_word_unpacker_if.slave bus
);
    localparam int unsigned R       = in_width / out_width;
    localparam int unsigned IdxW    = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned NumSlot = 2 ** IdxW;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(R - 1);

    if ((in_width % out_width) != 0 || R < 2) begin : g_bad_widths
        $error("fifo_word_unpacker: in_width must be a multiple (>=2x) of out_width");
    end

    typedef enum logic {
        StEmpty = 1'b0,
        StHold  = 1'b1
    } state_e;

    logic [1:0]             rst_sync_q;
    logic                   rst_ni;
    state_e                 state_q, state_d;
    logic [in_width-1:0]    hold_q, hold_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [count_width-1:0] count_q, count_d;
    logic                   in_ready;
    logic                   pop;
    logic                   out_xfer;
    logic                   last_slice;
    logic [out_width-1:0]   slices [NumSlot];

    // Reset synchronizer: asserts immediately, releases two clock edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_ni = rst_sync_q[1];

    // Slice k of the held word; slots past R-1 are unreachable and tied to zero.
    for (genvar k = 0; k < NumSlot; k++) begin : g_slice
        if (k >= R) begin : g_pad
            assign slices[k] = '0;
        end else if (msb_first) begin : g_msb
            assign slices[k] = hold_q[in_width-1-k*out_width -: out_width];
        end else begin : g_lsb
            assign slices[k] = hold_q[k*out_width +: out_width];
        end
    end

    // Pop only when empty or when the final slice leaves this cycle; never looks at in_enable.
    assign last_slice = (idx_q == LastIdx);
    assign in_ready   = (state_q == StEmpty) || (last_slice && bus.out_ready);
    assign pop        = in_ready && bus.in_enable;
    assign out_xfer   = (state_q == StHold) && bus.out_ready;

    assign bus.in_ready   = in_ready;
    assign bus.out_enable = (state_q == StHold);
    assign bus.busy       = (state_q == StHold);
    assign bus.out_data   = slices[idx_q];
    assign bus.count      = count_q;

    // Next state: advance on a slice transfer, then let a pop override (capture wins on last).
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        count_d = count_q;
        if (out_xfer) begin
            count_d = count_q + count_width'(1);
            if (last_slice) begin
                state_d = StEmpty;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
        if (pop) begin
            state_d = StHold;
            hold_d  = bus.in_data;
            idx_d   = '0;
        end
    end

    // State registers, cleared by the synchronized reset.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            hold_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker: three instances (32/8 msb-first, 32/8 lsb-first,
// 16/4 msb-first) plus a randomized run on the default instance against a slice queue.
module tb_fifo_word_unpacker;
    logic clk;
    logic reset_n;
    int   tests_run;
    int   fails;
    int   cnt_a;
    int   cnt_b;
    int   cnt_c;

    fifo_word_unpacker_if #(.in_width(32), .out_width(8), .count_width(16)) a_if ();
    fifo_word_unpacker_if #(.in_width(32), .out_width(8), .count_width(16)) b_if ();
    fifo_word_unpacker_if #(.in_width(16), .out_width(4), .count_width(16)) c_if ();

    fifo_word_unpacker #(.in_width(32), .out_width(8), .msb_first(1'b1), .count_width(16)) u_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a_if)
    );
    fifo_word_unpacker #(.in_width(32), .out_width(8), .msb_first(1'b0), .count_width(16)) u_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b_if)
    );
    fifo_word_unpacker #(.in_width(16), .out_width(4), .msb_first(1'b1), .count_width(16)) u_c (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (c_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (a_if.out_enable !== 1'b0 || a_if.busy !== 1'b0 || a_if.out_data !== 8'h00 ||
            a_if.in_ready !== 1'b1 || a_if.count !== 16'd0) begin
            fails++;
            $display("FAIL reset_a: got en=%b busy=%b data=%h rdy=%b cnt=%0d expected 0 0 00 1 0",
                     a_if.out_enable, a_if.busy, a_if.out_data, a_if.in_ready, a_if.count);
        end
        tests_run++;
        if (b_if.out_enable !== 1'b0 || c_if.out_enable !== 1'b0 || b_if.count !== 16'd0 ||
            c_if.count !== 16'd0 || c_if.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_bc: got b_en=%b c_en=%b b_cnt=%0d c_cnt=%0d c_rdy=%b expected 0 0 0 0 1",
                     b_if.out_enable, c_if.out_enable, b_if.count, c_if.count, c_if.in_ready);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_s [4];
        exp_s = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        a_if.in_data   = 32'hA1B2C3D4;
        a_if.in_enable = 1'b1;
        a_if.out_ready = 1'b1;
        #1;
        tests_run++;
        if (a_if.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_pop_ready: got %b expected 1", a_if.in_ready);
        end
        tick();
        a_if.in_enable = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (a_if.out_enable !== 1'b1 || a_if.out_data !== exp_s[k] ||
                a_if.in_ready !== (k == 3)) begin
                fails++;
                $display("FAIL single_slice%0d: got en=%b data=%h rdy=%b expected en=1 data=%h rdy=%b",
                         k, a_if.out_enable, a_if.out_data, a_if.in_ready, exp_s[k], (k == 3));
            end
            tick();
            #1;
        end
        cnt_a += 4;
        tests_run++;
        if (a_if.out_enable !== 1'b0 || a_if.in_ready !== 1'b1 || a_if.count !== 16'(cnt_a)) begin
            fails++;
            $display("FAIL single_done: got en=%b rdy=%b cnt=%0d expected en=0 rdy=1 cnt=%0d",
                     a_if.out_enable, a_if.in_ready, a_if.count, cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        int pops;
        pops = 0;
        a_if.in_data   = 32'h01020304;
        a_if.in_enable = 1'b1;
        a_if.out_ready = 1'b1;
        #1;
        if (a_if.in_enable && a_if.in_ready) pops++;
        tick();
        a_if.in_data = 32'h05060708;
        #1;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (a_if.out_enable !== 1'b1 || a_if.out_data !== 8'(k + 1)) begin
                fails++;
                $display("FAIL b2b_slice%0d: got en=%b data=%h expected en=1 data=%h",
                         k, a_if.out_enable, a_if.out_data, 8'(k + 1));
            end
            if (a_if.in_enable && a_if.in_ready) pops++;
            tick();
            if (k == 3) a_if.in_enable = 1'b0;
            #1;
        end
        cnt_a += 8;
        tests_run++;
        if (pops != 2 || a_if.out_enable !== 1'b0 || a_if.count !== 16'(cnt_a)) begin
            fails++;
            $display("FAIL b2b_done: got pops=%0d en=%b cnt=%0d expected pops=2 en=0 cnt=%0d",
                     pops, a_if.out_enable, a_if.count, cnt_a);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_s [3];
        exp_s = '{8'hB2, 8'hC3, 8'hD4};
        a_if.in_data   = 32'hA1B2C3D4;
        a_if.in_enable = 1'b1;
        a_if.out_ready = 1'b1;
        #1;
        tick();
        a_if.in_enable = 1'b0;
        #1;
        tests_run++;
        if (a_if.out_data !== 8'hA1) begin
            fails++;
            $display("FAIL bp_first: got %h expected a1", a_if.out_data);
        end
        tick();
        a_if.out_ready = 1'b0;
        a_if.in_data   = 32'hDEADBEEF;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (a_if.out_enable !== 1'b1 || a_if.out_data !== 8'hB2 || a_if.in_ready !== 1'b0 ||
                a_if.count !== 16'(cnt_a + 1)) begin
                fails++;
                $display("FAIL bp_stall%0d: got en=%b data=%h rdy=%b cnt=%0d expected 1 b2 0 %0d",
                         i, a_if.out_enable, a_if.out_data, a_if.in_ready, a_if.count, cnt_a + 1);
            end
            tick();
            a_if.in_data = 32'(32'h13572468 * (i + 1));
            #1;
        end
        a_if.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (a_if.out_enable !== 1'b1 || a_if.out_data !== exp_s[k]) begin
                fails++;
                $display("FAIL bp_resume%0d: got en=%b data=%h expected en=1 data=%h",
                         k, a_if.out_enable, a_if.out_data, exp_s[k]);
            end
            tick();
            #1;
        end
        cnt_a += 4;
        tests_run++;
        if (a_if.out_enable !== 1'b0 || a_if.count !== 16'(cnt_a)) begin
            fails++;
            $display("FAIL bp_done: got en=%b cnt=%0d expected en=0 cnt=%0d",
                     a_if.out_enable, a_if.count, cnt_a);
        end
    endtask

    task automatic test_slice_order();
        logic [7:0] exp_b [4];
        logic [3:0] exp_c [4];
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        exp_c = '{4'hB, 4'hE, 4'hE, 4'hF};
        b_if.in_data   = 32'hA1B2C3D4;
        c_if.in_data   = 16'hBEEF;
        b_if.in_enable = 1'b1;
        c_if.in_enable = 1'b1;
        b_if.out_ready = 1'b1;
        c_if.out_ready = 1'b1;
        #1;
        tick();
        b_if.in_enable = 1'b0;
        c_if.in_enable = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (b_if.out_enable !== 1'b1 || b_if.out_data !== exp_b[k]) begin
                fails++;
                $display("FAIL lsb_slice%0d: got en=%b data=%h expected en=1 data=%h",
                         k, b_if.out_enable, b_if.out_data, exp_b[k]);
            end
            tests_run++;
            if (c_if.out_enable !== 1'b1 || c_if.out_data !== exp_c[k]) begin
                fails++;
                $display("FAIL narrow_slice%0d: got en=%b data=%h expected en=1 data=%h",
                         k, c_if.out_enable, c_if.out_data, exp_c[k]);
            end
            tick();
            #1;
        end
        cnt_b += 4;
        cnt_c += 4;
        tests_run++;
        if (b_if.count !== 16'(cnt_b) || c_if.count !== 16'(cnt_c) || c_if.out_enable !== 1'b0) begin
            fails++;
            $display("FAIL order_done: got b_cnt=%0d c_cnt=%0d c_en=%b expected %0d %0d 0",
                     b_if.count, c_if.count, c_if.out_enable, cnt_b, cnt_c);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_s [4];
        exp_s = '{8'h11, 8'h22, 8'h33, 8'h44};
        a_if.in_data   = 32'hA1B2C3D4;
        a_if.in_enable = 1'b1;
        a_if.out_ready = 1'b1;
        #1;
        tick();
        a_if.in_enable = 1'b0;
        #1;
        tick();
        tick();
        #1;
        tests_run++;
        if (a_if.out_data !== 8'hC3 || a_if.count !== 16'(cnt_a + 2)) begin
            fails++;
            $display("FAIL mid_pre: got data=%h cnt=%0d expected c3 %0d",
                     a_if.out_data, a_if.count, cnt_a + 2);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (a_if.out_enable !== 1'b0 || a_if.busy !== 1'b0 || a_if.count !== 16'd0 ||
            a_if.in_ready !== 1'b1 || b_if.count !== 16'd0) begin
            fails++;
            $display("FAIL mid_async: got en=%b busy=%b cnt=%0d rdy=%b b_cnt=%0d expected 0 0 0 1 0",
                     a_if.out_enable, a_if.busy, a_if.count, a_if.in_ready, b_if.count);
        end
        #1;
        reset_n = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        repeat (3) tick();
        a_if.in_data   = 32'h11223344;
        a_if.in_enable = 1'b1;
        #1;
        tick();
        a_if.in_enable = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (a_if.out_enable !== 1'b1 || a_if.out_data !== exp_s[k]) begin
                fails++;
                $display("FAIL mid_after%0d: got en=%b data=%h expected en=1 data=%h",
                         k, a_if.out_enable, a_if.out_data, exp_s[k]);
            end
            tick();
            #1;
        end
        cnt_a += 4;
        tests_run++;
        if (a_if.out_enable !== 1'b0 || a_if.count !== 16'(cnt_a)) begin
            fails++;
            $display("FAIL mid_done: got en=%b cnt=%0d expected en=0 cnt=%0d",
                     a_if.out_enable, a_if.count, cnt_a);
        end
    endtask

    task automatic test_random();
        logic [7:0]  sb [$];
        logic [7:0]  exp_v;
        logic [31:0] w;
        int          sent;
        int          cycles;
        bit          pending;
        sent    = 0;
        cycles  = 0;
        pending = 1'b0;
        while ((sent < 1000 || sb.size() != 0) && cycles < 30000) begin
            tick();
            cycles++;
            if (!pending) begin
                a_if.in_enable = 1'b0;
                if (sent < 1000 && $urandom_range(1, 0) == 1) begin
                    a_if.in_data   = $urandom();
                    a_if.in_enable = 1'b1;
                    pending        = 1'b1;
                end
            end
            a_if.out_ready = ($urandom_range(9, 0) < 7);
            #1;
            if (a_if.out_enable && a_if.out_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra: got data=%h expected no slice", a_if.out_data);
                end else begin
                    exp_v = sb.pop_front();
                    if (a_if.out_data !== exp_v) begin
                        fails++;
                        $display("FAIL rand_slice: got %h expected %h", a_if.out_data, exp_v);
                    end
                end
            end
            if (a_if.in_enable && a_if.in_ready) begin
                w = a_if.in_data;
                for (int k = 0; k < 4; k++) sb.push_back(w[31-8*k -: 8]);
                sent++;
                pending = 1'b0;
            end
        end
        a_if.in_enable = 1'b0;
        tests_run++;
        if (sent != 1000 || sb.size() != 0) begin
            fails++;
            $display("FAIL rand_timeout: got sent=%0d left=%0d expected 1000 0", sent, sb.size());
        end
        tick();
        #1;
        cnt_a += 4 * sent;
        tests_run++;
        if (a_if.out_enable !== 1'b0 || a_if.count !== 16'(cnt_a)) begin
            fails++;
            $display("FAIL rand_count: got en=%b cnt=%0d expected en=0 cnt=%0d",
                     a_if.out_enable, a_if.count, 16'(cnt_a));
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        cnt_a     = 0;
        cnt_b     = 0;
        cnt_c     = 0;
        reset_n   = 1'b0;
        a_if.in_data = '0; a_if.in_enable = 1'b0; a_if.out_ready = 1'b0;
        b_if.in_data = '0; b_if.in_enable = 1'b0; b_if.out_ready = 1'b0;
        c_if.in_data = '0; c_if.in_enable = 1'b0; c_if.out_ready = 1'b0;
        #12;
        test_reset();
        reset_n = 1'b1;
        repeat (3) tick();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_slice_order();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
